mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between two requesters: the instruction-fetch path (ifu/imu side) and the load/store path (register/data_mem side). This replaces the current split instruction/data memories.
- Sequences each access with a req/ack handshake and serves one transaction at a time.
- Generates the core-wide stall while any access is outstanding, and times out hung memory transactions.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits (range 1..15)
- TIMEOUT, 64, cycles to wait for mem_ack before abort (range 2..255)
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetched word; valid when if_ack
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  load/store request; held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid when d_ack
- d_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion, single cycle
- stall  out  1  core stall
- timeout_err  out  1  sticky error flag

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-transaction drops mem_req immediately and discards the transaction.
- All outputs are registered except stall.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Both requests high: grant data, unless d_streak==MAX_D_STREAK, in which case grant fetch.
  - Only one request high: grant it.
  - On grant: latch addr/we/wdata into mem_* (mem_we forced 0 for fetch), set mem_req=1, go to ISSUE.
- d_streak:
  - Increments on a data grant made while if_req=1 (saturates).
  - Clears on a fetch grant, or when IDLE sees if_req=0.
- ISSUE:
  - mem_* outputs are held constant.
  - The timeout counter increments each cycle that mem_ack=0.
  - On mem_ack: capture mem_rdata into the granted requester's rdata, pulse its ack next cycle, mem_req=0, go to RESP.
  - If the counter reaches TIMEOUT-1 with no mem_ack: mem_req=0, rdata=ERR_DATA, pulse ack, set timeout_err, go to RESP.
  - A mem_ack arriving in the same cycle as the timeout wins: normal completion, no error.
- RESP:
  - The ack is high for exactly this one cycle; requests are ignored.
  - Next state is IDLE.
  - The requester must deassert req in the cycle after its ack, or issue a new request.
- Latency: req seen in IDLE at cycle 0 → mem_req high at cycle 1 → mem_ack at cycle k≥1 → ack/rdata at cycle k+1. Minimum is 2 cycles req→ack, with a back-to-back throughput of one transaction per 3 cycles.
- Store: d_rdata is updated with mem_rdata anyway; the value is don't-care for the core.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational. It is 0 in reset.
- timeout_err: sticky; cleared only by reset.
- Requests that change addr while pending are illegal; the arbiter uses only the values latched at grant.

Decomposition:
- Shared package riscv_pkg:
  - arb_state_t enum {IDLE, ISSUE, RESP}
  - localparams ARB_ERR_DATA, ARB_TIMEOUT_DEFAULT
- One natural sub-module, arb_timeout_cnt: a loadable down-counter with an expire flag.
- Grant logic and d_streak stay inline.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10, mem_ack at cycle 1 with rdata 0x00500093 → if_ack and if_rdata=0x00500093 at cycle 2; stall high for cycles 0–1 only.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xCAFE0001, mem_ack after 3 wait cycles → mem_we=1 and mem_addr=0x40 stable until ack; d_ack at cycle 5; if_ack never pulses.
- Simultaneous: if_req and d_req high together from IDLE, MAX_D_STREAK=4, continuous d_req → grant order D,D,D,D,I,D…; fetch served after at most 4 data transactions.
- Timeout: fetch with mem_ack never asserted, TIMEOUT=64 → mem_req drops after 64 cycles; if_ack with if_rdata=0xDEADBEEF; timeout_err=1 and stays 1 until reset.
- Timeout race: mem_ack in exactly the expiry cycle → normal completion with mem_rdata returned; timeout_err stays 0.
- Reset mid-transaction: assert reset during ISSUE with mem_req=1 → mem_req, acks, stall and timeout_err go to 0 asynchronously; after release, the next request is granted normally from IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory port arbiter.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  localparam logic [31:0] ARB_ERR_DATA        = 32'hDEAD_BEEF;
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;
  localparam int unsigned ARB_STREAK_W        = 4;
  localparam int unsigned ARB_CNT_W           = 8;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Loadable down-counter with an expire flag.
//   clk, reset        : clock, async active-high reset
//   load, load_val    : reload the count
//   dec               : decrement by one (holds at zero)
//   expired           : count has reached zero
module arb_timeout_cnt
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ARB_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 expired
);

  logic [ARB_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store paths,
// one req/ack transaction at a time, with core stall and ack timeout.
//   if_*   : fetch requester      d_*   : load/store requester
//   mem_*  : shared memory port   stall : core stall (combinational)
//   timeout_err : sticky flag, set when a memory access is aborted
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       MAX_D_STREAK = 4,
  parameter int unsigned       TIMEOUT      = ARB_TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0] ERR_DATA     = DATA_W'(ARB_ERR_DATA)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              timeout_err
);

  arb_state_t              state;
  logic                    gnt_d;
  logic [ARB_STREAK_W-1:0] d_streak;
  logic                    grant_d;
  logic                    cnt_load;
  logic                    cnt_dec;
  logic                    cnt_expired;

  // Data wins a collision unless it has already starved fetch for MAX_D_STREAK grants.
  always_comb begin
    grant_d = d_req && !(if_req && (d_streak == ARB_STREAK_W'(MAX_D_STREAK)));
  end

  always_comb begin
    cnt_load = (state == IDLE);
    cnt_dec  = (state == ISSUE) && !mem_ack;
  end

  arb_timeout_cnt u_timeout_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (ARB_CNT_W'(TIMEOUT - 1)),
    .dec      (cnt_dec),
    .expired  (cnt_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt_d       <= 1'b0;
      d_streak    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      if_ack      <= 1'b0;
      d_rdata     <= '0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_req) begin
            d_streak <= '0;
          end
          if (grant_d) begin
            gnt_d     <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= ISSUE;
            if (if_req && (d_streak != '1)) begin
              d_streak <= d_streak + 1'b1;
            end
          end else if (if_req) begin
            gnt_d     <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= ISSUE;
            d_streak  <= '0;
          end
        end
        ISSUE: begin
          // mem_ack takes priority over an expiry in the same cycle.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (gnt_d) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end else if (cnt_expired) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RESP;
            if (gnt_d) begin
              d_rdata <= ERR_DATA;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= ERR_DATA;
              if_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall = !reset && ((if_req && !if_ack) || (d_req && !d_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        timeout_err;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (4),
    .TIMEOUT      (64),
    .ERR_DATA     (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stall       (stall),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        if_q[$];
  exp_t        d_q[$];
  logic [31:0] grant_log[$];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  int          ack_wait  = 0;
  logic [31:0] resp_data = '0;
  logic        echo_addr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks ack_wait cycles after mem_req rises (ack_wait<0: never).
  initial begin
    int   wcnt;
    logic prev_req;
    logic acked;
    wcnt      = 0;
    prev_req  = 1'b0;
    acked     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !reset) begin
        if (!prev_req) begin
          grant_log.push_back(mem_addr);
          wcnt  = 0;
          acked = 1'b0;
        end
        if (!acked && (ack_wait >= 0) && (wcnt == ack_wait)) begin
          mem_ack   = 1'b1;
          mem_rdata = echo_addr ? {16'h5A5A, mem_addr[15:0]} : resp_data;
          acked     = 1'b1;
        end
        wcnt++;
      end
      prev_req = mem_req && !reset;
    end
  end

  // Scoreboard monitor: pops an expectation on every ack pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (if_ack) begin
          if (if_q.size() == 0) begin
            check("if_ack_unexpected", 32'd1, 32'd0);
          end else begin
            e = if_q.pop_front();
            check("if_rdata", if_rdata, e.data);
            check("if_ack_cycle", cyc, e.due);
          end
        end
        if (d_ack) begin
          if (d_q.size() == 0) begin
            check("d_ack_unexpected", 32'd1, 32'd0);
          end else begin
            e = d_q.pop_front();
            check("d_rdata", d_rdata, e.data);
            check("d_ack_cycle", cyc, e.due);
          end
        end
      end
    end
  end

  task automatic run_single(input string tag, input logic is_d, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int wait_c, input logic [31:0] mrdata,
                            input logic [31:0] exp_rdata, input int exp_lat,
                            input int exp_mem_cycles);
    int   mem_cycles;
    logic got;
    exp_t e;
    @(negedge clk);
    ack_wait  = wait_c;
    resp_data = mrdata;
    echo_addr = 1'b0;
    e.data    = exp_rdata;
    e.due     = cyc + exp_lat;
    if (is_d) begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      d_q.push_back(e);
    end else begin
      if_req  = 1'b1;
      if_addr = addr;
      if_q.push_back(e);
    end
    mem_cycles = 0;
    got        = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      got = is_d ? d_ack : if_ack;
      if (got) check({tag, "_stall_at_ack"}, {31'd0, stall}, 32'd0);
      else     check({tag, "_stall_pending"}, {31'd0, stall}, 32'd1);
      check({tag, "_other_ack"}, {31'd0, (is_d ? if_ack : d_ack)}, 32'd0);
      if (mem_req) begin
        mem_cycles++;
        check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, is_d & we});
        check({tag, "_mem_addr"}, mem_addr, addr);
      end
    end
    if (!got) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    check({tag, "_mem_req_cycles"}, mem_cycles, exp_mem_cycles);
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   nd;
    logic fetch_done;
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (3) @(negedge clk);
    if_req = 1'b1;
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_if_ack", {31'd0, if_ack}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_single("fetch", 1'b0, 1'b0, 32'h10, 32'h0, 0, 32'h0050_0093, 32'h0050_0093, 2, 1);
    run_single("store", 1'b1, 1'b1, 32'h40, 32'hCAFE_0001, 3, 32'h1234_5678, 32'h1234_5678, 5, 4);
    check("store_wdata_latched", mem_wdata, 32'hCAFE_0001);
    run_single("load", 1'b1, 1'b0, 32'h44, 32'h0, 1, 32'hA5A5_0044, 32'hA5A5_0044, 3, 2);
    run_single("race", 1'b0, 1'b0, 32'h20, 32'h0, 63, 32'h1357_9BDF, 32'h1357_9BDF, 65, 64);
    check("race_no_err", {31'd0, timeout_err}, 32'd0);

    // Collision: continuous data stream against one pending fetch.
    grant_log.delete();
    @(negedge clk);
    ack_wait  = 0;
    echo_addr = 1'b1;
    if_req    = 1'b1;
    if_addr   = 32'h100;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h200;
    d_q.push_back('{32'h5A5A_0200, cyc + 2});
    d_q.push_back('{32'h5A5A_0204, cyc + 5});
    d_q.push_back('{32'h5A5A_0208, cyc + 8});
    d_q.push_back('{32'h5A5A_020C, cyc + 11});
    if_q.push_back('{32'h5A5A_0100, cyc + 14});
    d_q.push_back('{32'h5A5A_0210, cyc + 17});
    nd         = 0;
    fetch_done = 1'b0;
    for (int n = 0; n < 60 && nd < 5; n++) begin
      @(negedge clk);
      if (if_ack) begin
        if_req     = 1'b0;
        fetch_done = 1'b1;
      end
      if (d_ack) begin
        nd++;
        if (nd == 5) d_req = 1'b0;
        else         d_addr = d_addr + 32'd4;
      end
    end
    d_req = 1'b0;
    if_req = 1'b0;
    echo_addr = 1'b0;
    check("arb_data_acks", nd, 32'd5);
    check("arb_fetch_done", {31'd0, fetch_done}, 32'd1);
    check("arb_grant_count", grant_log.size(), 32'd6);
    if (grant_log.size() == 6) begin
      check("arb_grant0", grant_log[0], 32'h200);
      check("arb_grant1", grant_log[1], 32'h204);
      check("arb_grant2", grant_log[2], 32'h208);
      check("arb_grant3", grant_log[3], 32'h20C);
      check("arb_grant4", grant_log[4], 32'h100);
      check("arb_grant5", grant_log[5], 32'h210);
    end

    run_single("tmo", 1'b0, 1'b0, 32'h30, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 65, 64);
    check("tmo_err_set", {31'd0, timeout_err}, 32'd1);
    run_single("after_tmo", 1'b0, 1'b0, 32'h34, 32'h0, 0, 32'h0000_1111, 32'h0000_1111, 2, 1);
    check("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset while the memory access is outstanding.
    @(negedge clk);
    ack_wait = -1;
    if_req   = 1'b1;
    if_addr  = 32'h80;
    repeat (3) @(negedge clk);
    check("midrst_mem_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_if_ack", {31'd0, if_ack}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_single("post_rst", 1'b0, 1'b0, 32'h84, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 2, 1);

    repeat (3) @(negedge clk);
    check("if_q_drained", if_q.size(), 32'd0);
    check("d_q_drained", d_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
